// File: rtl/spatial_encoder_param.sv
// -----------------------------------------------------------------------------
// spatial_encoder_param
//
// Purpose:
//   Spatial hypervector encoder for up to three modalities. One input vector
//   is accepted in IDLE. In RUN the block walks the channels of every enabled
//   modality in parallel. It fetches IM/projNeg/projPos hypervectors from
//   per-modality SRAMs and binds each channel as IM ^ (sign ? projNeg : projPos).
//   It bundles the channels of each modality by per-bit majority, with a
//   tie-break vote for even channel counts. It then combines the enabled
//   modalities into one output hypervector, which is held in DONE until
//   downstream takes it.
//
// Ports:
//   Clk_CI             clock
//   Reset_RI           synchronous, active-high reset
//   ValidIn_SI         input vector valid
//   ReadyOut_SO        block accepts an input vector (IDLE only)
//   ChannelsInput_DI   CHANNEL_WIDTH*TOTAL_CH channel features, channel 0 in MSBs
//   ModMask_SI         modality enable mask, bit i = modality i+1
//   SramReq_SO         per-modality SRAM read request
//   SramValid_SI       per-modality SRAM data valid (IM, projNeg, projPos together)
//   SramAddr_DO        per-modality global channel address, modality i in slice i
//   IM_DI              per-modality item-memory data, modality i in slice i
//   ProjNeg_DI         per-modality negative projection data
//   ProjPos_DI         per-modality positive projection data
//   ValidOut_SO        result valid (DONE only)
//   ReadyIn_SI         downstream ready
//   HypervectorOut_DO  encoded hypervector
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Valid is never withdrawn before that edge. Data and valid are held
// stable while ready is 0. The upstream side is ValidIn_SI/ReadyOut_SO and
// the downstream side is ValidOut_SO/ReadyIn_SI.
// -----------------------------------------------------------------------------
module spatial_encoder_param #(
   parameter int HV_DIMENSION  = 2000,
   parameter int CHANNEL_WIDTH = 4,
   parameter int MOD1_CHANNELS = 32,
   parameter int MOD2_CHANNELS = 77,
   parameter int MOD3_CHANNELS = 105,
   localparam int TOTAL_CH = MOD1_CHANNELS + MOD2_CHANNELS + MOD3_CHANNELS,
   localparam int MAX_CH   = (MOD1_CHANNELS > MOD2_CHANNELS)
                             ? ((MOD1_CHANNELS > MOD3_CHANNELS) ? MOD1_CHANNELS : MOD3_CHANNELS)
                             : ((MOD2_CHANNELS > MOD3_CHANNELS) ? MOD2_CHANNELS : MOD3_CHANNELS),
   localparam int ADDR_W   = (TOTAL_CH > 1) ? $clog2(TOTAL_CH) : 1,
   localparam int CNT_W    = $clog2(MAX_CH + 1)
) (
   input  logic                              Clk_CI,
   input  logic                              Reset_RI,
   input  logic                              ValidIn_SI,
   output logic                              ReadyOut_SO,
   input  logic [CHANNEL_WIDTH*TOTAL_CH-1:0] ChannelsInput_DI,
   input  logic [2:0]                        ModMask_SI,
   output logic [2:0]                        SramReq_SO,
   input  logic [2:0]                        SramValid_SI,
   output logic [3*ADDR_W-1:0]               SramAddr_DO,
   input  logic [3*HV_DIMENSION-1:0]         IM_DI,
   input  logic [3*HV_DIMENSION-1:0]         ProjNeg_DI,
   input  logic [3*HV_DIMENSION-1:0]         ProjPos_DI,
   output logic                              ValidOut_SO,
   input  logic                              ReadyIn_SI,
   output logic [HV_DIMENSION-1:0]           HypervectorOut_DO
);

   localparam int MOD_CH [3] = '{MOD1_CHANNELS, MOD2_CHANNELS, MOD3_CHANNELS};
   localparam int BASE   [3] = '{0, MOD1_CHANNELS, MOD1_CHANNELS + MOD2_CHANNELS};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // State. state_q is the FSM state that checkers bind to.
   // ---------------------------------------------------------------------------
   state_t                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [2:0]              mask_q;
   logic [TOTAL_CH-1:0]     ch_sign_q;     // feature MSB per global channel
   logic [CNT_W-1:0]        acc_q  [3][HV_DIMENSION];
   logic [HV_DIMENSION-1:0] tie_q  [3];
   logic [HV_DIMENSION-1:0] hv_q;

   // ---------------------------------------------------------------------------
   // Feature sign extraction. Binding only looks at the feature MSB, so only
   // that bit is registered. The lower feature bits are folded into a
   // deliberately unused net.
   // ---------------------------------------------------------------------------
   logic [TOTAL_CH-1:0] ch_sign_in;
   logic                unused_feature_lsbs;

   always_comb begin
      ch_sign_in          = '0;
      unused_feature_lsbs = 1'b0;
      for (int g = 0; g < TOTAL_CH; g++) begin
         ch_sign_in[g] = ChannelsInput_DI[(TOTAL_CH-1-g)*CHANNEL_WIDTH + CHANNEL_WIDTH-1];
         for (int k = 0; k < CHANNEL_WIDTH-1; k++) begin
            unused_feature_lsbs = unused_feature_lsbs
                                ^ ChannelsInput_DI[(TOTAL_CH-1-g)*CHANNEL_WIDTH + k];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Channel count of the longest enabled modality; its last channel ends RUN.
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] max_n;
   logic             last_cnt;

   always_comb begin
      max_n = '0;
      for (int m = 0; m < 3; m++) begin
         if (mask_q[m] && (MOD_CH[m] > int'(max_n))) begin
            max_n = CNT_W'(MOD_CH[m]);
         end
      end
   end

   assign last_cnt = (cnt_q == (max_n - CNT_W'(1)));

   // ---------------------------------------------------------------------------
   // Per-modality request, address and channel binding
   // ---------------------------------------------------------------------------
   logic [2:0]              active;
   logic [2:0][ADDR_W-1:0]  addr;
   logic [2:0]              sign_sel;
   logic [HV_DIMENSION-1:0] ch_hv [3];
   logic                    advance;

   always_comb begin
      for (int m = 0; m < 3; m++) begin
         active[m]   = (state_q == ST_RUN) && mask_q[m] && (int'(cnt_q) < MOD_CH[m]);
         addr[m]     = active[m] ? ADDR_W'(BASE[m] + int'(cnt_q)) : '0;
         sign_sel[m] = ch_sign_q[addr[m]];
         ch_hv[m]    = IM_DI[m*HV_DIMENSION +: HV_DIMENSION]
                     ^ (sign_sel[m] ? ProjNeg_DI[m*HV_DIMENSION +: HV_DIMENSION]
                                    : ProjPos_DI[m*HV_DIMENSION +: HV_DIMENSION]);
      end
   end

   // The counter only moves when every modality that is still walking has its
   // SRAM data. Modalities that have already finished are ignored.
   assign advance = (state_q == ST_RUN) && ((active & ~SramValid_SI) == 3'b000);

   // ---------------------------------------------------------------------------
   // Next accumulator and tie-break values, and the bundles formed from them.
   // The bundles are taken from the next values so that the last channel
   // counts on the cycle that registers the output.
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0]        acc_nxt [3][HV_DIMENSION];
   logic [HV_DIMENSION-1:0] tie_nxt [3];
   logic [HV_DIMENSION-1:0] bundle  [3];

   always_comb begin
      for (int m = 0; m < 3; m++) begin
         for (int b = 0; b < HV_DIMENSION; b++) begin
            acc_nxt[m][b] = acc_q[m][b] + CNT_W'(active[m] & ch_hv[m][b]);
         end

         // For an even channel count, the tie vote is channel 0 XOR channel 1.
         // Channel 0 is parked in the register first.
         tie_nxt[m] = tie_q[m];
         if (((MOD_CH[m] % 2) == 0) && active[m]) begin
            if (cnt_q == CNT_W'(0)) begin
               tie_nxt[m] = ch_hv[m];
            end else if (cnt_q == CNT_W'(1)) begin
               tie_nxt[m] = tie_q[m] ^ ch_hv[m];
            end
         end

         for (int b = 0; b < HV_DIMENSION; b++) begin
            bundle[m][b] = (int'(acc_nxt[m][b])
                            + ((((MOD_CH[m] % 2) == 0) && tie_nxt[m][b]) ? 1 : 0))
                           > (MOD_CH[m] / 2);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Cross-modality combination. Masking disabled modalities to all-ones
   // gives an AND of the enabled ones, which also covers the single-modality
   // case.
   // ---------------------------------------------------------------------------
   logic [HV_DIMENSION-1:0] en_and;
   logic [HV_DIMENSION-1:0] hv_final;

   always_comb begin
      en_and = '1;
      for (int m = 0; m < 3; m++) begin
         if (mask_q[m]) begin
            en_and = en_and & bundle[m];
         end
      end
      case (mask_q)
         3'b000:  hv_final = '0;
         3'b111:  hv_final = (bundle[0] & bundle[1]) | (bundle[0] & bundle[2])
                           | (bundle[1] & bundle[2]);
         default: hv_final = en_and;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM and datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk_CI) begin
      if (Reset_RI) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         mask_q    <= '0;
         ch_sign_q <= '0;
         hv_q      <= '0;
         for (int m = 0; m < 3; m++) begin
            tie_q[m] <= '0;
            for (int b = 0; b < HV_DIMENSION; b++) begin
               acc_q[m][b] <= '0;
            end
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ValidIn_SI) begin
                  ch_sign_q <= ch_sign_in;
                  mask_q    <= ModMask_SI;
                  cnt_q     <= '0;
                  hv_q      <= '0;
                  for (int m = 0; m < 3; m++) begin
                     tie_q[m] <= '0;
                     for (int b = 0; b < HV_DIMENSION; b++) begin
                        acc_q[m][b] <= '0;
                     end
                  end
                  // An empty mask has nothing to walk; the result is all zeros.
                  state_q <= (ModMask_SI == 3'b000) ? ST_DONE : ST_RUN;
               end
            end

            ST_RUN: begin
               if (advance) begin
                  for (int m = 0; m < 3; m++) begin
                     tie_q[m] <= tie_nxt[m];
                     for (int b = 0; b < HV_DIMENSION; b++) begin
                        acc_q[m][b] <= acc_nxt[m][b];
                     end
                  end
                  if (last_cnt) begin
                     hv_q    <= hv_final;
                     state_q <= ST_DONE;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end

            ST_DONE: begin
               if (ReadyIn_SI) begin
                  state_q <= ST_IDLE;
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign ReadyOut_SO       = (state_q == ST_IDLE) && !Reset_RI;
   assign ValidOut_SO       = (state_q == ST_DONE);
   assign HypervectorOut_DO = hv_q;
   assign SramReq_SO        = active;
   assign SramAddr_DO       = addr;

endmodule

// File: tb/tb_spatial_encoder_param.sv
// -----------------------------------------------------------------------------
// tb_spatial_encoder_param
//
// Directed bench for spatial_encoder_param with HV_DIMENSION=8, CHANNEL_WIDTH=4
// and modality channel counts 1, 2 and 3. Global channels: modality 1 = {0},
// modality 2 = {1,2}, modality 3 = {3,4,5}.
// -----------------------------------------------------------------------------
module tb_spatial_encoder_param;

   localparam int HV  = 8;
   localparam int CW  = 4;
   localparam int M1  = 1;
   localparam int M2  = 2;
   localparam int M3  = 3;
   localparam int TOT = M1 + M2 + M3;
   localparam int AW  = 3;

   // ---------------------------------------------------------------------------
   // Clock / reset and DUT signals
   // ---------------------------------------------------------------------------
   logic              Clk_CI = 1'b0;
   logic              Reset_RI;
   logic              ValidIn_SI;
   logic              ReadyOut_SO;
   logic [TOT*CW-1:0] ChannelsInput_DI;
   logic [2:0]        ModMask_SI;
   logic [2:0]        SramReq_SO;
   logic [2:0]        SramValid_SI;
   logic [3*AW-1:0]   SramAddr_DO;
   logic [3*HV-1:0]   IM_DI;
   logic [3*HV-1:0]   ProjNeg_DI;
   logic [3*HV-1:0]   ProjPos_DI;
   logic              ValidOut_SO;
   logic              ReadyIn_SI;
   logic [HV-1:0]     HypervectorOut_DO;

   always #5 Clk_CI = ~Clk_CI;

   spatial_encoder_param #(
      .HV_DIMENSION (HV),
      .CHANNEL_WIDTH(CW),
      .MOD1_CHANNELS(M1),
      .MOD2_CHANNELS(M2),
      .MOD3_CHANNELS(M3)
   ) dut (
      .Clk_CI           (Clk_CI),
      .Reset_RI         (Reset_RI),
      .ValidIn_SI       (ValidIn_SI),
      .ReadyOut_SO      (ReadyOut_SO),
      .ChannelsInput_DI (ChannelsInput_DI),
      .ModMask_SI       (ModMask_SI),
      .SramReq_SO       (SramReq_SO),
      .SramValid_SI     (SramValid_SI),
      .SramAddr_DO      (SramAddr_DO),
      .IM_DI            (IM_DI),
      .ProjNeg_DI       (ProjNeg_DI),
      .ProjPos_DI       (ProjPos_DI),
      .ValidOut_SO      (ValidOut_SO),
      .ReadyIn_SI       (ReadyIn_SI),
      .HypervectorOut_DO(HypervectorOut_DO)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard state
   // ---------------------------------------------------------------------------
   int            n_checks = 0;
   int            n_errors = 0;
   logic [HV-1:0] exp_q[$];
   logic [2:0]    req_log  [0:15];
   logic [3*AW-1:0] addr_log [0:15];
   int            stall_start = 0;
   int            stall_len   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic set_mod(input int m, input logic [HV-1:0] im,
                          input logic [HV-1:0] pos, input logic [HV-1:0] neg);
      IM_DI[m*HV +: HV]      = im;
      ProjPos_DI[m*HV +: HV] = pos;
      ProjNeg_DI[m*HV +: HV] = neg;
   endtask

   // Presents one vector and returns #1 after the accept edge. Afterwards the
   // inputs are scrambled so that late input changes would corrupt a result.
   task automatic accept(input logic [2:0] mask, input logic [TOT*CW-1:0] chans,
                         input logic [HV-1:0] exp_hv, input bit push);
      @(negedge Clk_CI);
      ValidIn_SI       = 1'b1;
      ModMask_SI       = mask;
      ChannelsInput_DI = chans;
      #1;
      check("ready_before_accept", 32'(ReadyOut_SO), 32'd1);
      if (push) exp_q.push_back(exp_hv);
      @(posedge Clk_CI);
      #1;
      ValidIn_SI       = 1'b0;
      ModMask_SI       = ~mask;
      ChannelsInput_DI = ~chans;
   endtask

   // Counts cycles from the accept edge until ValidOut_SO, logs the SRAM
   // requests/addresses of each cycle and applies the stall window.
   task automatic wait_done(input string tag, input int exp_lat);
      int            lat;
      bit            done;
      logic [HV-1:0] e;
      lat  = 0;
      done = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (ValidOut_SO) begin
            done = 1'b1;
            break;
         end
         if (lat < 16) begin
            req_log[lat]  = SramReq_SO;
            addr_log[lat] = SramAddr_DO;
         end
         SramValid_SI = (lat >= stall_start && lat < stall_start + stall_len) ? 3'b011 : 3'b111;
         @(posedge Clk_CI);
         #1;
         lat++;
      end
      SramValid_SI = 3'b111;
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, "_hv"}, 32'(HypervectorOut_DO), 32'(e));
      end else begin
         check({tag, "_hv_no_expectation"}, 32'd1, 32'd0);
      end
   endtask

   task automatic release_out();
      ReadyIn_SI = 1'b1;
      @(posedge Clk_CI);
      #1;
      ReadyIn_SI = 1'b0;
      check("idle_valid", 32'(ValidOut_SO), 32'd0);
      check("idle_ready", 32'(ReadyOut_SO), 32'd1);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      Reset_RI         = 1'b1;
      ValidIn_SI       = 1'b0;
      ModMask_SI       = 3'b000;
      ChannelsInput_DI = '0;
      SramValid_SI     = 3'b111;
      ReadyIn_SI       = 1'b0;
      IM_DI            = '0;
      ProjNeg_DI       = '0;
      ProjPos_DI       = '0;

      // Reset held for two cycles
      repeat (2) @(posedge Clk_CI);
      #1;
      check("rst_hv",    32'(HypervectorOut_DO), 32'd0);
      check("rst_valid", 32'(ValidOut_SO),       32'd0);
      check("rst_req",   32'(SramReq_SO),        32'd0);
      check("rst_addr",  32'(SramAddr_DO),       32'd0);
      Reset_RI = 1'b0;
      @(negedge Clk_CI);
      check("rst_ready_after", 32'(ReadyOut_SO), 32'd1);

      // Single modality: 0x0F ^ 0xFF = 0xF0
      set_mod(0, 8'h0F, 8'hFF, 8'h00);
      accept(3'b001, 24'h333333, 8'hF0, 1'b1);
      wait_done("single", 1);
      check("single_req0",  32'(req_log[0]),  32'd1);
      check("single_addr0", 32'(addr_log[0]), 32'd0);
      release_out();

      // Full mask, all positive: every channel HV is 0xAA
      for (int m = 0; m < 3; m++) set_mod(m, 8'h00, 8'hAA, 8'h55);
      accept(3'b111, 24'h333333, 8'hAA, 1'b1);
      wait_done("full", 3);
      check("full_req0",  32'(req_log[0]),  32'd7);
      check("full_req1",  32'(req_log[1]),  32'd6);
      check("full_req2",  32'(req_log[2]),  32'd4);
      check("full_addr0", 32'(addr_log[0]), 32'd200);  // {3,1,0}
      check("full_addr1", 32'(addr_log[1]), 32'd272);  // {4,2,0}
      check("full_addr2", 32'(addr_log[2]), 32'd320);  // {5,0,0}
      release_out();

      // Modality 2 alone: HVs 0x3C, 0x5A; tie vote 0x66 lifts the 1-of-2 bits
      set_mod(1, 8'h0F, 8'h33, 8'h55);
      accept(3'b010, 24'h338333, 8'h7E, 1'b1);
      wait_done("tie", 2);
      release_out();

      // Empty mask right after a nonzero result
      accept(3'b000, 24'h123456, 8'h00, 1'b1);
      wait_done("empty_after_result", 0);
      release_out();

      // Modalities 1 and 3: bundle1 = 0x3C, bundle3 = majority(CC,0F,0F) = 0x0F
      set_mod(0, 8'h00, 8'h3C, 8'hC3);
      set_mod(1, 8'hFF, 8'hFF, 8'hFF);
      set_mod(2, 8'h00, 8'hCC, 8'h0F);
      accept(3'b101, 24'h333388, 8'h0C, 1'b1);
      wait_done("pair", 3);
      release_out();

      // Stall of modality 3 for four cycles
      for (int m = 0; m < 3; m++) set_mod(m, 8'h00, 8'hAA, 8'h55);
      stall_start = 1;
      stall_len   = 4;
      accept(3'b111, 24'h333333, 8'hAA, 1'b1);
      wait_done("stall", 7);
      stall_len = 0;
      check("stall_addr4", 32'(addr_log[4]), 32'd272);
      check("stall_addr5", 32'(addr_log[5]), 32'd272);
      check("stall_addr6", 32'(addr_log[6]), 32'd320);

      // Backpressure: hold for five cycles
      for (int i = 0; i < 5; i++) begin
         @(posedge Clk_CI);
         #1;
         check("bp_valid", 32'(ValidOut_SO),       32'd1);
         check("bp_hv",    32'(HypervectorOut_DO), 32'hAA);
         check("bp_ready", 32'(ReadyOut_SO),       32'd0);
      end
      release_out();

      // Reset in the second RUN cycle, then an empty mask
      accept(3'b111, 24'h333333, 8'hAA, 1'b0);
      @(posedge Clk_CI);
      #1;
      Reset_RI = 1'b1;
      @(posedge Clk_CI);
      #1;
      Reset_RI = 1'b0;
      check("abort_valid", 32'(ValidOut_SO),       32'd0);
      check("abort_req",   32'(SramReq_SO),        32'd0);
      check("abort_addr",  32'(SramAddr_DO),       32'd0);
      check("abort_hv",    32'(HypervectorOut_DO), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge Clk_CI);
         #1;
         check("abort_no_valid", 32'(ValidOut_SO), 32'd0);
      end
      accept(3'b000, 24'h888888, 8'h00, 1'b1);
      wait_done("empty", 0);
      release_out();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/spatial_encoder_param.md
SPATIAL_ENCODER_PARAM -- requirements
Module: spatial_encoder_param

Interface
REQ-001 Parameters SHALL be:
- HV_DIMENSION, 2000, hypervector width.
- CHANNEL_WIDTH, 4, bits per channel feature.
- MOD1_CHANNELS, 32, channel count of modality 1 (>=1).
- MOD2_CHANNELS, 77, channel count of modality 2 (>=1).
- MOD3_CHANNELS, 105, channel count of modality 3 (>=1).
REQ-002 Derived values SHALL be:
- TOTAL_CH = sum of the three channel counts.
- ADDR_W = ceilLog2(TOTAL_CH).
- CNT_W = ceilLog2(max channel count + 1).
REQ-003 Ports SHALL be:
- Clk_CI  in  1  clock.
- Reset_RI  in  1  reset.
- ValidIn_SI  in  1  input vector valid.
- ReadyOut_SO  out  1  block accepts an input vector.
- ChannelsInput_DI  in  CHANNEL_WIDTH*TOTAL_CH  channel features; channel 0 in the MSBs.
- ModMask_SI  in  3  modality enable mask; bit i = modality i+1.
- SramReq_SO  out  3  per-modality SRAM read request.
- SramValid_SI  in  3  per-modality SRAM data valid, covering the IM, projNeg and projPos banks together.
- SramAddr_DO  out  3*ADDR_W  per-modality global channel address.
- IM_DI, ProjNeg_DI, ProjPos_DI  in  3*HV_DIMENSION each  per-modality SRAM data.
- ValidOut_SO  out  1  result valid.
- ReadyIn_SI  in  1  downstream ready.
- HypervectorOut_DO  out  HV_DIMENSION  encoded hypervector.
REQ-004 The block SHALL use one clock, Clk_CI; Reset_RI SHALL be synchronous and active-high.

Function
REQ-005 FSM states SHALL be IDLE, RUN and DONE; ReadyOut_SO=1 only in IDLE; ValidOut_SO=1 only in DONE.
REQ-006 In IDLE with ValidIn_SI=1, the block SHALL register all channels and ModMask_SI, clear the counter and accumulators, and go to RUN; if the mask is 000 it SHALL go directly to DONE with output 0.
REQ-007 Modality i SHALL be active in RUN when its mask bit is 1 and counter < MODi_CHANNELS.
REQ-008 SramReq_SO[i] SHALL be 1 exactly when modality i is active.
REQ-009 SramAddr_DO[i] SHALL be base_i + counter while modality i is active, and 0 otherwise.
- base_1 = 0.
- base_2 = MOD1_CHANNELS.
- base_3 = MOD1_CHANNELS + MOD2_CHANNELS.
REQ-010 A RUN cycle SHALL advance only when SramValid_SI is 1 for every active modality; otherwise the counter and all accumulators SHALL hold (stall).
REQ-011 On advance, the channel HV for each active modality SHALL be IM XOR (feature MSB=1 ? ProjNeg : ProjPos), and each bit SHALL add into that modality's per-bit counter.
REQ-012 For even MODi_CHANNELS, the block SHALL store the XOR of the channel-0 and channel-1 HVs as a tie-break vote.
REQ-013 Modality bundle bit SHALL be 1 when (count + tiebreak) > floor(MODi_CHANNELS/2); the tie-break term applies only for even channel counts.
REQ-014 The final HV SHALL be formed from the enabled modalities:
- Three enabled: bitwise majority.
- Two enabled: bitwise AND.
- One enabled: that modality's bundle.
- None enabled: 0.
REQ-015 On the advance where counter = (max enabled channel count - 1), the final HV SHALL be registered into HypervectorOut_DO and the state SHALL go to DONE.
REQ-016 Latency with no stalls SHALL be exactly max-enabled-channel-count cycles from the accept edge to ValidOut_SO=1; each stall cycle SHALL add exactly one cycle.
REQ-017 In DONE, HypervectorOut_DO and ValidOut_SO SHALL hold until ReadyIn_SI=1, then the block SHALL return to IDLE on that edge.
REQ-018 Input changes outside IDLE acceptance SHALL have no effect on the result.

Reset
REQ-019 While Reset_RI=1 the block SHALL force:
- state IDLE; counter, accumulators and tie-break registers 0.
- HypervectorOut_DO=0, ValidOut_SO=0, SramReq_SO=000, SramAddr_DO=0.
- ReadyOut_SO=1 from the first cycle after reset deasserts.
REQ-020 Reset asserted during RUN or DONE SHALL abandon the operation and produce no ValidOut_SO pulse.

Verification (HV_DIMENSION=8, CHANNEL_WIDTH=4, MODi_CHANNELS=1,2,3)
REQ-021 Reset check: assert Reset_RI for 2 cycles -> all outputs 0; ReadyOut_SO=1 after release.
REQ-022 Single-modality check: mask=001, IM1=0x0F, ProjPos1=0xFF, feature0=0x3, SramValid=111 -> ValidOut_SO=1 one cycle after accept, HypervectorOut_DO=0xF0.
REQ-023 Full-mask check: mask=111, all IM=0x00, all ProjPos=0xAA, all features positive -> HypervectorOut_DO=0xAA after 3 cycles; SramAddr_DO[2] walks 3,4,5; SramReq_SO[0] drops after cycle 1.
REQ-024 Stall check: repeat REQ-023 with SramValid_SI[2]=0 for 4 cycles mid-RUN -> counter frozen, latency 7, result 0xAA.
REQ-025 Backpressure check: ReadyIn_SI=0 for 5 cycles in DONE -> output stable, ReadyOut_SO=0; after ReadyIn_SI=1, IDLE on the next edge.
REQ-026 Reset-abort and empty-mask check: reset in the 2nd RUN cycle, then a new vector with mask=000 -> no stale ValidOut_SO; next cycle DONE with output 0x00.
